// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline latch enable/flush producer.
// Drives the PC enable and the enable/flush pair of every pipeline latch.
// Handles load-use bubbles, EX-resolved redirects, memory waits and halt.
// Also keeps saturating stall and flush performance counters.
module hazard_stall_ctrl #(
  parameter int LOADUSE_BUBBLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       rs_ID,
  input  logic [4:0]       rt_ID,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic             memtoReg_EX,
  input  logic             RegWr_EX,
  input  logic [4:0]       wreg_EX,
  input  logic             redirect_EX,
  input  logic             ihit,
  input  logic             dmem_req_MEM,
  input  logic             dhit,
  input  logic             halt_MEM,
  output logic             pc_en,
  output logic             en_IFID,
  output logic             en_IDEX,
  output logic             en_EXMEM,
  output logic             en_MEMWB,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LUSTALL, HALTED} state_t;

  // Extra bubbles still owed after the first load-use cycle.
  localparam logic [1:0] BUB_INIT = 2'(LOADUSE_BUBBLES - 1);

  state_t     state, state_nxt;
  logic [1:0] bub_cnt, bub_cnt_nxt;
  logic       load_use;
  logic       freeze;
  logic       redirect_take;

  // Hazard detection: load in EX feeding a register that ID actually reads.
  always_comb begin
    load_use = memtoReg_EX && RegWr_EX && (wreg_EX != 5'd0) &&
               ((uses_rs && (rs_ID == wreg_EX)) || (uses_rt && (rt_ID == wreg_EX)));
    freeze   = dmem_req_MEM && !dhit;
  end

  // Next-state and latch control, applying the per-cycle priority order.
  always_comb begin
    state_nxt     = state;
    bub_cnt_nxt   = bub_cnt;
    redirect_take = 1'b0;
    pc_en         = 1'b1;
    en_IFID       = 1'b1;
    en_IDEX       = 1'b1;
    en_EXMEM      = 1'b1;
    en_MEMWB      = 1'b1;
    flush_IFID    = 1'b0;
    flush_IDEX    = 1'b0;
    flush_EXMEM   = 1'b0;
    halted        = 1'b0;
    if (RST) begin
      pc_en       = 1'b0;
      en_IFID     = 1'b0;
      en_IDEX     = 1'b0;
      en_EXMEM    = 1'b0;
      en_MEMWB    = 1'b0;
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      flush_EXMEM = 1'b1;
    end else begin
      case (state)
        RUN, LUSTALL: begin
          if (halt_MEM) begin
            pc_en     = 1'b0;
            en_IFID   = 1'b0;
            en_IDEX   = 1'b0;
            en_EXMEM  = 1'b0;
            state_nxt = HALTED;
          end else if (freeze) begin
            pc_en    = 1'b0;
            en_IFID  = 1'b0;
            en_IDEX  = 1'b0;
            en_EXMEM = 1'b0;
            en_MEMWB = 1'b0;
          end else if (state == LUSTALL) begin
            pc_en       = 1'b0;
            en_IFID     = 1'b0;
            flush_IDEX  = 1'b1;
            bub_cnt_nxt = 2'(bub_cnt - 2'd1);
            if (bub_cnt == 2'd1) begin
              state_nxt = RUN;
            end
          end else if (redirect_EX) begin
            flush_IFID    = 1'b1;
            flush_IDEX    = 1'b1;
            redirect_take = 1'b1;
          end else if (load_use) begin
            pc_en      = 1'b0;
            en_IFID    = 1'b0;
            flush_IDEX = 1'b1;
            if (LOADUSE_BUBBLES > 1) begin
              state_nxt   = LUSTALL;
              bub_cnt_nxt = BUB_INIT;
            end
          end else if (!ihit) begin
            pc_en      = 1'b0;
            flush_IFID = 1'b1;
          end
        end
        HALTED: begin
          pc_en    = 1'b0;
          en_IFID  = 1'b0;
          en_IDEX  = 1'b0;
          en_EXMEM = 1'b0;
          en_MEMWB = 1'b0;
          halted   = 1'b1;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // State and bubble counter register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= RUN;
      bub_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      bub_cnt <= bub_cnt_nxt;
    end
  end

  // Saturating performance counters for stalled cycles and taken redirects.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_en && (state != HALTED) && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (redirect_take && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: three instances share one input set
// (1 bubble, 2 bubbles, and 1 bubble with 2-bit counters for saturation).
module tb_hazard_stall_ctrl;

  // Packed output order: {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
  //                       flush_IFID, flush_IDEX, flush_EXMEM, halted}
  localparam logic [8:0] EXP_RUN     = 9'b1_1111_000_0;
  localparam logic [8:0] EXP_NOHIT   = 9'b0_1111_100_0;
  localparam logic [8:0] EXP_LU      = 9'b0_0111_010_0;
  localparam logic [8:0] EXP_REDIR   = 9'b1_1111_110_0;
  localparam logic [8:0] EXP_FRZ     = 9'b0_0000_000_0;
  localparam logic [8:0] EXP_HALTCYC = 9'b0_0001_000_0;
  localparam logic [8:0] EXP_HALTED  = 9'b0_0000_000_1;
  localparam logic [8:0] EXP_RST     = 9'b0_0000_111_0;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mem;
    logic       rw;
    logic [4:0] wreg;
    logic       redir;
    logic       ihit;
    logic       dreq;
    logic       dhit;
    logic       halt;
    logic [8:0] exp;
  } vec_t;

  logic CLK, RST;
  logic [4:0] rs_ID, rt_ID, wreg_EX;
  logic uses_rs, uses_rt, memtoReg_EX, RegWr_EX, redirect_EX, ihit, dmem_req_MEM, dhit, halt_MEM;

  logic pc_en_1, en_IFID_1, en_IDEX_1, en_EXMEM_1, en_MEMWB_1, flush_IFID_1, flush_IDEX_1, flush_EXMEM_1, halted_1;
  logic pc_en_2, en_IFID_2, en_IDEX_2, en_EXMEM_2, en_MEMWB_2, flush_IFID_2, flush_IDEX_2, flush_EXMEM_2, halted_2;
  logic pc_en_3, en_IFID_3, en_IDEX_3, en_EXMEM_3, en_MEMWB_3, flush_IFID_3, flush_IDEX_3, flush_EXMEM_3, halted_3;
  logic [31:0] stall_cnt_1, flush_cnt_1, stall_cnt_2, flush_cnt_2;
  logic [1:0]  stall_cnt_3, flush_cnt_3;
  logic [8:0]  out1, out2, out3;

  int checks = 0;
  int errors = 0;

  vec_t vecs[15];
  vec_t idle, lu, frz, frz_done, lu_redir, halt_v, nohit, redir;

  assign out1 = {pc_en_1, en_IFID_1, en_IDEX_1, en_EXMEM_1, en_MEMWB_1, flush_IFID_1, flush_IDEX_1, flush_EXMEM_1, halted_1};
  assign out2 = {pc_en_2, en_IFID_2, en_IDEX_2, en_EXMEM_2, en_MEMWB_2, flush_IFID_2, flush_IDEX_2, flush_EXMEM_2, halted_2};
  assign out3 = {pc_en_3, en_IFID_3, en_IDEX_3, en_EXMEM_3, en_MEMWB_3, flush_IFID_3, flush_IDEX_3, flush_EXMEM_3, halted_3};

  hazard_stall_ctrl #(.LOADUSE_BUBBLES(1), .CNT_W(32)) dut1 (
    .CLK(CLK), .RST(RST), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .memtoReg_EX(memtoReg_EX), .RegWr_EX(RegWr_EX), .wreg_EX(wreg_EX), .redirect_EX(redirect_EX),
    .ihit(ihit), .dmem_req_MEM(dmem_req_MEM), .dhit(dhit), .halt_MEM(halt_MEM),
    .pc_en(pc_en_1), .en_IFID(en_IFID_1), .en_IDEX(en_IDEX_1), .en_EXMEM(en_EXMEM_1), .en_MEMWB(en_MEMWB_1),
    .flush_IFID(flush_IFID_1), .flush_IDEX(flush_IDEX_1), .flush_EXMEM(flush_EXMEM_1), .halted(halted_1),
    .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1));

  hazard_stall_ctrl #(.LOADUSE_BUBBLES(2), .CNT_W(32)) dut2 (
    .CLK(CLK), .RST(RST), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .memtoReg_EX(memtoReg_EX), .RegWr_EX(RegWr_EX), .wreg_EX(wreg_EX), .redirect_EX(redirect_EX),
    .ihit(ihit), .dmem_req_MEM(dmem_req_MEM), .dhit(dhit), .halt_MEM(halt_MEM),
    .pc_en(pc_en_2), .en_IFID(en_IFID_2), .en_IDEX(en_IDEX_2), .en_EXMEM(en_EXMEM_2), .en_MEMWB(en_MEMWB_2),
    .flush_IFID(flush_IFID_2), .flush_IDEX(flush_IDEX_2), .flush_EXMEM(flush_EXMEM_2), .halted(halted_2),
    .stall_cnt(stall_cnt_2), .flush_cnt(flush_cnt_2));

  hazard_stall_ctrl #(.LOADUSE_BUBBLES(1), .CNT_W(2)) dut3 (
    .CLK(CLK), .RST(RST), .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .memtoReg_EX(memtoReg_EX), .RegWr_EX(RegWr_EX), .wreg_EX(wreg_EX), .redirect_EX(redirect_EX),
    .ihit(ihit), .dmem_req_MEM(dmem_req_MEM), .dhit(dhit), .halt_MEM(halt_MEM),
    .pc_en(pc_en_3), .en_IFID(en_IFID_3), .en_IDEX(en_IDEX_3), .en_EXMEM(en_EXMEM_3), .en_MEMWB(en_MEMWB_3),
    .flush_IFID(flush_IFID_3), .flush_IDEX(flush_IDEX_3), .flush_EXMEM(flush_EXMEM_3), .halted(halted_3),
    .stall_cnt(stall_cnt_3), .flush_cnt(flush_cnt_3));

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic vec_t mkVec(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic mem, input logic rw, input logic [4:0] wreg,
                                 input logic redir, input logic ih, input logic dreq, input logic dh,
                                 input logic hlt, input logic [8:0] exp);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.mem = mem; v.rw = rw; v.wreg = wreg;
    v.redir = redir; v.ihit = ih; v.dreq = dreq; v.dhit = dh; v.halt = hlt; v.exp = exp;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rs_ID = v.rs; rt_ID = v.rt; uses_rs = v.urs; uses_rt = v.urt;
    memtoReg_EX = v.mem; RegWr_EX = v.rw; wreg_EX = v.wreg; redirect_EX = v.redir;
    ihit = v.ihit; dmem_req_MEM = v.dreq; dhit = v.dhit; halt_MEM = v.halt;
  endtask

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Holds reset for one rising edge and checks the forced reset outputs.
  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1;
    applyStimulus(idle);
    #1;
    checkOutput("reset_outputs", out2, EXP_RST);
  endtask

  // Drives one cycle of inputs at the falling edge, settles before sampling.
  task automatic nextCycle(input vec_t v);
    @(negedge CLK);
    RST = 1'b0;
    applyStimulus(v);
    #1;
  endtask

  initial begin
    idle     = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 0, EXP_RUN);
    lu       = mkVec(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 1, 0, 0, 0, EXP_LU);
    frz      = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 0, 0, EXP_FRZ);
    frz_done = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 1, 0, EXP_RUN);
    lu_redir = mkVec(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 1, 1, 0, 0, 0, EXP_REDIR);
    halt_v   = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 1, EXP_HALTCYC);
    nohit    = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0, EXP_NOHIT);
    redir    = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0, 0, EXP_REDIR);

    vecs[0]  = idle;
    vecs[1]  = nohit;
    vecs[2]  = lu;
    vecs[3]  = mkVec(5'd3, 5'd8, 0, 1, 1, 1, 5'd8, 0, 1, 0, 0, 0, EXP_LU);
    vecs[4]  = mkVec(5'd8, 5'd0, 0, 0, 1, 1, 5'd8, 0, 1, 0, 0, 0, EXP_RUN);
    vecs[5]  = mkVec(5'd0, 5'd0, 1, 0, 1, 1, 5'd0, 0, 1, 0, 0, 0, EXP_RUN);
    vecs[6]  = mkVec(5'd8, 5'd0, 1, 0, 0, 1, 5'd8, 0, 1, 0, 0, 0, EXP_RUN);
    vecs[7]  = mkVec(5'd8, 5'd0, 1, 0, 1, 0, 5'd8, 0, 1, 0, 0, 0, EXP_RUN);
    vecs[8]  = lu_redir;
    vecs[9]  = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0, EXP_REDIR);
    vecs[10] = frz;
    vecs[11] = frz_done;
    vecs[12] = mkVec(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 1, 1, 1, 0, 0, EXP_FRZ);
    vecs[13] = mkVec(5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 1, 1, 0, 1, EXP_HALTCYC);
    vecs[14] = mkVec(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 0, 0, 0, 0, 0, EXP_LU);

    RST = 1'b1;
    applyStimulus(idle);

    // Single-cycle vectors, each applied fresh out of reset.
    for (int i = 0; i < 15; i++) begin
      doReset();
      nextCycle(vecs[i]);
      checkOutput($sformatf("vec%0d", i), out1, vecs[i].exp);
    end

    // Load-use with one and two bubbles.
    doReset();
    nextCycle(lu);
    checkOutput("lu1_bubble", out1, EXP_LU);
    checkOutput("lu2_bubble_a", out2, EXP_LU);
    nextCycle(idle);
    checkOutput("lu1_resume", out1, EXP_RUN);
    checkOutput("lu2_bubble_b", out2, EXP_LU);
    checkCount("lu1_stall_cnt", stall_cnt_1, 32'd1);
    nextCycle(idle);
    checkOutput("lu2_resume", out2, EXP_RUN);
    checkCount("lu2_stall_cnt", stall_cnt_2, 32'd2);
    checkCount("lu1_stall_cnt_hold", stall_cnt_1, 32'd1);

    // Load-use squashed by a same-cycle redirect.
    doReset();
    nextCycle(lu_redir);
    checkOutput("redir_lu1", out1, EXP_REDIR);
    checkOutput("redir_lu2", out2, EXP_REDIR);
    nextCycle(idle);
    checkOutput("redir_after2", out2, EXP_RUN);
    checkCount("redir_flush_cnt", flush_cnt_1, 32'd1);
    checkCount("redir_stall_cnt", stall_cnt_1, 32'd0);
    checkCount("redir_flush_cnt2", flush_cnt_2, 32'd1);

    // Data-memory freeze in the middle of a two-bubble stall.
    doReset();
    nextCycle(lu);
    for (int c = 0; c < 3; c++) begin
      nextCycle(frz);
      checkOutput($sformatf("frz2_c%0d", c), out2, EXP_FRZ);
      checkOutput($sformatf("frz1_c%0d", c), out1, EXP_FRZ);
    end
    nextCycle(frz_done);
    checkOutput("frz2_bubble_held", out2, EXP_LU);
    checkOutput("frz1_release", out1, EXP_RUN);
    nextCycle(idle);
    checkOutput("frz2_resume", out2, EXP_RUN);
    checkCount("frz2_stall_cnt", stall_cnt_2, 32'd5);
    checkCount("frz1_stall_cnt", stall_cnt_1, 32'd4);

    // Halt freeze, ignored inputs while halted, reset exit.
    doReset();
    nextCycle(halt_v);
    checkOutput("halt_cycle", out1, EXP_HALTCYC);
    nextCycle(mkVec(5'd8, 5'd0, 1, 0, 1, 1, 5'd8, 1, 0, 1, 1, 1, EXP_HALTED));
    checkOutput("halted_a", out1, EXP_HALTED);
    nextCycle(idle);
    checkOutput("halted_b", out1, EXP_HALTED);
    checkCount("halt_stall_cnt", stall_cnt_1, 32'd1);
    checkCount("halt_flush_cnt", flush_cnt_1, 32'd0);
    doReset();
    nextCycle(idle);
    checkOutput("halt_exit", out1, EXP_RUN);
    checkCount("halt_exit_stall_cnt", stall_cnt_1, 32'd0);

    // Reset in the middle of a bubble stall abandons it.
    doReset();
    nextCycle(lu);
    doReset();
    nextCycle(idle);
    checkOutput("rst_mid_stall", out2, EXP_RUN);
    checkCount("rst_mid_stall_cnt", stall_cnt_2, 32'd0);

    // Counter saturation on the 2-bit instance.
    doReset();
    for (int c = 0; c < 5; c++) nextCycle(nohit);
    nextCycle(idle);
    checkCount("sat_stall_cnt", {30'd0, stall_cnt_3}, 32'd3);
    doReset();
    for (int c = 0; c < 4; c++) nextCycle(redir);
    nextCycle(idle);
    checkCount("sat_flush_cnt", {30'd0, flush_cnt_3}, 32'd3);
    checkCount("sat_redir_stall", {30'd0, stall_cnt_3}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
